// File: rtl/hilbert_weight_ctrl_pkg.sv
// Shared Hilbert constants: frame geometry, weight-stage latency and the
// sequencing states of the weight controller.
package hilbert_weight_ctrl_pkg;

    // Samples per frame; equals the depth of the twiddle table.
    localparam int HWC_FRAME_LEN = 16;
    // Weight-stage latency counted in ED cycles.
    localparam int HWC_PIPE_LAT  = 2;
    // ED-cycle counter width; must hold FRAME_LEN + PIPE_LAT - 1.
    localparam int HWC_CNT_W     = 5;
    // Width of the output sample index.
    localparam int HWC_IDX_W     = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM1  = 3'd1,
        ST_ARM2  = 3'd2,
        ST_RUN   = 3'd3,
        ST_FLUSH = 3'd4,
        ST_DRAIN = 3'd5,
        ST_DONE  = 3'd6
    } hwc_state_t;

    // A framing error is an in_last flag that disagrees with the counter
    // position of the last sample in the frame.
    function automatic logic framing_error(input logic last_flag, input logic at_last);
        return last_flag ^ at_last;
    endfunction

endpackage

// File: rtl/hilbert_weight_ctrl.sv
// Sequencer for the Hilbert weight stage: issues the two-cycle START, gates
// the ED strobe from the upstream/downstream handshakes, flushes the weight
// pipeline at the end of each frame and tags outputs with index/last.
//
// state | meaning
// IDLE  | waiting for go (and for the weight-stage reset to be captured)
// ARM1  | first START cycle, counter cleared
// ARM2  | second START cycle
// RUN   | accepting FRAME_LEN samples, one ED per accepted sample
// FLUSH | ED without input to push the last PIPE_LAT results out
// DRAIN | waiting for the final output to be taken
// DONE  | one-cycle frame_done pulse
module hilbert_weight_ctrl
    import hilbert_weight_ctrl_pkg::*;
#(
    parameter int FRAME_LEN = HWC_FRAME_LEN,
    parameter int PIPE_LAT  = HWC_PIPE_LAT,
    parameter int CNT_W     = HWC_CNT_W
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 go,
    output logic                 busy,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic [HWC_IDX_W-1:0] out_idx,
    output logic                 wt_rst,
    output logic                 wt_start,
    output logic                 wt_ed,
    output logic                 frame_done,
    output logic                 err
);

    localparam logic [CNT_W-1:0] CNT_IN_LAST    = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_FLUSH_LAST = CNT_W'(FRAME_LEN + PIPE_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_FIRST_OUT  = CNT_W'(PIPE_LAT);

    hwc_state_t       state;
    hwc_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic             cnt_clr;
    logic             at_in_last;
    logic             at_flush_last;
    logic             out_take;
    logic             new_sample;

    assign at_in_last    = (cnt == CNT_IN_LAST);
    assign at_flush_last = (cnt == CNT_FLUSH_LAST);
    assign out_take      = out_valid & out_ready;
    // An ED beyond the pipeline latency produces a fresh result at its edge.
    assign new_sample    = wt_ed & (cnt >= CNT_FIRST_OUT);

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake/strobe decode; ED is withheld whenever an
    // untaken output is pending so the weight outputs stay stable.
    always_comb begin
        state_next = state;
        wt_start   = 1'b0;
        wt_ed      = 1'b0;
        in_ready   = 1'b0;
        busy       = 1'b1;
        frame_done = 1'b0;
        cnt_clr    = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (go && !wt_rst) begin
                    state_next = ST_ARM1;
                    cnt_clr    = 1'b1;
                end
            end
            ST_ARM1: begin
                wt_start   = 1'b1;
                state_next = ST_ARM2;
            end
            ST_ARM2: begin
                wt_start   = 1'b1;
                state_next = ST_RUN;
            end
            ST_RUN: begin
                wt_ed    = in_valid & (out_ready | ~out_valid);
                in_ready = wt_ed;
                if (wt_ed && at_in_last) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                wt_ed = out_ready | ~out_valid;
                if (wt_ed && at_flush_last) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!out_valid || out_ready) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                frame_done = 1'b1;
                if (go) begin
                    state_next = ST_ARM1;
                    cnt_clr    = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ED-cycle counter, cleared on every entry to ARM1.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (wt_ed) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Output qualifier: a new result loads index/last, a taken result with
    // nothing behind it drops valid.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_idx   <= '0;
        end else if (new_sample) begin
            out_valid <= 1'b1;
            out_idx   <= HWC_IDX_W'(cnt - CNT_FIRST_OUT);
            out_last  <= at_flush_last;
        end else if (out_take) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

    // Sticky framing error; the frame still runs to its full length.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err <= 1'b0;
        end else if ((state == ST_RUN) && wt_ed && framing_error(in_last, at_in_last)) begin
            err <= 1'b1;
        end
    end

    // Weight-stage synchronous reset: held through RST and for the first
    // clock edge after release so the weight stage captures it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wt_rst <= 1'b1;
        end else begin
            wt_rst <= 1'b0;
        end
    end

endmodule
